bp_me_cache_dma_initiator: RTL

- Block-granular DMA initiator: accepts one read or write command per block and drives the bsg_cache DMA interface (packet, fill-data out, fill-data in) as the requesting side.
- Pairs with the nonsynth DRAM models and the AXI/test-DRAM adapters, which are the responding side.
- Used by ME test benches and by uncached bulk-copy engines that need to reach DRAM without an L2 cache.
- Single outstanding transaction; the command is buffered, then serialized into or deserialized from fill beats.

---
 rtl/bp_me_cache_dma_initiator.sv | 105 ++++++++++
 1 files changed

// File: rtl/bp_me_cache_dma_initiator.sv
// Block-granular DMA initiator: buffers one read/write command and drives the
// bsg_cache DMA packet / fill-beat interface as the requesting side.
module bp_me_cache_dma_initiator
  #(parameter int daddr_width_p           = 32
  , parameter int l2_fill_width_p         = 64
  , parameter int l2_block_size_in_fill_p = 8
  , localparam int block_width_lp         = l2_fill_width_p*l2_block_size_in_fill_p
  , localparam int dma_pkt_width_lp       = 1+daddr_width_p
  )
  (input  logic                        clk_i
  , input  logic                        reset_n_i

  , input  logic                        req_v_i
  , output logic                        req_ready_and_o
  , input  logic                        req_write_not_read_i
  , input  logic [daddr_width_p-1:0]    req_addr_i
  , input  logic [block_width_lp-1:0]   req_data_i

  , output logic                        resp_v_o
  , input  logic                        resp_ready_and_i
  , output logic                        resp_write_not_read_o
  , output logic [daddr_width_p-1:0]    resp_addr_o
  , output logic [block_width_lp-1:0]   resp_data_o

  , output logic [dma_pkt_width_lp-1:0] dma_pkt_o
  , output logic                        dma_pkt_v_o
  , input  logic                        dma_pkt_yumi_i

  , input  logic [l2_fill_width_p-1:0]  dma_data_i
  , input  logic                        dma_data_v_i
  , output logic                        dma_data_ready_and_o

  , output logic [l2_fill_width_p-1:0]  dma_data_o
  , output logic                        dma_data_v_o
  , input  logic                        dma_data_yumi_i
  );

    localparam int off_lp   = $clog2(block_width_lp/8);
    localparam int cnt_w_lp = (l2_block_size_in_fill_p > 1) ? $clog2(l2_block_size_in_fill_p) : 1;
    localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'(l2_block_size_in_fill_p-1);

    typedef enum logic [2:0] {e_ready, e_send_pkt, e_send_data, e_recv_data, e_resp} state_e;

    state_e                                                    state_r;
    logic                                                      wnr_r;
    logic [daddr_width_p-1:0]                                  addr_r;
    logic [l2_block_size_in_fill_p-1:0][l2_fill_width_p-1:0]   buf_r;
    logic [cnt_w_lp-1:0]                                       cnt_r;

    logic last_beat;
    assign last_beat = (cnt_r == last_lp);

    // Outputs decode straight from registered state; data fields are gated so
    // everything reads zero whenever the matching valid is low (incl. reset).
    assign req_ready_and_o       = reset_n_i & (state_r == e_ready);
    assign dma_pkt_v_o           = (state_r == e_send_pkt);
    assign dma_pkt_o             = dma_pkt_v_o ? {wnr_r, addr_r} : '0;
    assign dma_data_v_o          = (state_r == e_send_data);
    assign dma_data_o            = dma_data_v_o ? buf_r[cnt_r] : '0;
    assign dma_data_ready_and_o  = (state_r == e_recv_data);
    assign resp_v_o              = (state_r == e_resp);
    assign resp_write_not_read_o = resp_v_o & wnr_r;
    assign resp_addr_o           = resp_v_o ? addr_r : '0;
    assign resp_data_o           = (resp_v_o & ~wnr_r) ? buf_r : '0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_ready;
            wnr_r   <= 1'b0;
            addr_r  <= '0;
            buf_r   <= '0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                e_ready: if (req_v_i) begin
                    wnr_r   <= req_write_not_read_i;
                    addr_r  <= {req_addr_i[daddr_width_p-1:off_lp], {off_lp{1'b0}}};
                    buf_r   <= req_write_not_read_i ? req_data_i : '0;
                    state_r <= e_send_pkt;
                end
                e_send_pkt: if (dma_pkt_yumi_i) begin
                    cnt_r   <= '0;
                    state_r <= wnr_r ? e_send_data : e_recv_data;
                end
                e_send_data: if (dma_data_yumi_i) begin
                    cnt_r <= last_beat ? '0 : cnt_r + cnt_w_lp'(1);
                    if (last_beat) state_r <= e_resp;
                end
                e_recv_data: if (dma_data_v_i) begin
                    buf_r[cnt_r] <= dma_data_i;
                    cnt_r        <= last_beat ? '0 : cnt_r + cnt_w_lp'(1);
                    if (last_beat) state_r <= e_resp;
                end
                e_resp: if (resp_ready_and_i) state_r <= e_ready;
                default: state_r <= e_ready;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_pkt_yumi:  assert property (@(posedge clk_i) disable iff (!reset_n_i) dma_pkt_yumi_i |-> dma_pkt_v_o);
    a_data_yumi: assert property (@(posedge clk_i) disable iff (!reset_n_i) dma_data_yumi_i |-> dma_data_v_o);
`endif

endmodule
